fetch_sequencer: RTL and testbench

- Consumer and controller for the program counter. Samples the current PC address, reads a 16-bit instruction from synchronous instruction ROM, and forwards it to decode through a valid/ready handshake.
- Jumps, taken branches and halts are resolved locally. The block drives jump (Jflag/Jaddr) and advance (pc_adv) requests back to the program counter, closing the PC loop.

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_sequencer_return_stack.sv | 68 ++++++
 rtl/fetch_sequencer.sv | 178 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, opcode
// encodings and instruction field positions.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_DECIDE = 3'd3,
        S_ISSUE  = 3'd4,
        S_CWAIT  = 3'd5,
        S_SETTLE = 3'd6,
        S_HALT   = 3'd7
    } state_e;

    localparam int OPC_W  = 4;
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int TGT_HI = 9;
    localparam int TGT_LO = 0;
    localparam int OFS_HI = 7;
    localparam int OFS_LO = 0;
    localparam int OFS_W  = 8;

    localparam logic [OPC_W-1:0] OP_J    = 4'hA;
    localparam logic [OPC_W-1:0] OP_BEQZ = 4'hB;
    localparam logic [OPC_W-1:0] OP_JAL  = 4'hC;
    localparam logic [OPC_W-1:0] OP_RET  = 4'hD;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

endpackage

// File: rtl/fetch_sequencer_return_stack.sv
// Circular return-address stack for JAL/RET; a push when full overwrites the
// oldest entry. Instantiated only when FETCH_CALL_STACK_EN is defined.
module return_stack #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          Clear_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_addr,
    output logic [AW-1:0] top_addr,
    output logic          empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] top_ptr_s;
    logic [CW-1:0] count_q, count_d;
    logic          full_s;

    assign top_ptr_s = (wr_ptr_q == {PW{1'b0}}) ? LAST_IDX : wr_ptr_q - PW'(1'b1);
    assign top_addr  = mem_q[top_ptr_s];
    assign empty     = (count_q == {CW{1'b0}});
    assign full_s    = (count_q == FULL_CNT);

    // Next pointer/count/storage; the write pointer wraps so a full push lands on the oldest slot.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_addr;
            wr_ptr_d = (wr_ptr_q == LAST_IDX) ? {PW{1'b0}} : wr_ptr_q + PW'(1'b1);
            if (!full_s) begin
                count_d = count_q + CW'(1'b1);
            end else begin
                count_d = count_q;
            end
        end else if (pop && !empty) begin
            wr_ptr_d = top_ptr_s;
            count_d  = count_q - CW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Stack state register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!Clear_n) begin
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {AW{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/issue sequencer closing the PC loop (ROM read, decode handshake, local
// jump/branch/halt). FETCH_CALL_STACK_EN adds JAL/RET with a return stack.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 16
`ifdef FETCH_CALL_STACK_EN
    ,
    parameter int STACK_DEPTH = 4
`endif
) (
    input  logic          clk,
    input  logic          Clear_n,
    input  logic [AW-1:0] Caddr,
    output logic          imem_en,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_rdata,
    output logic [DW-1:0] instr,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          cond_valid,
    input  logic          cond_zero,
    output logic          pc_adv,
    output logic          Jflag,
    output logic [AW-1:0] Jaddr,
    output logic          halted
);
    state_e         state_q, state_d;
    logic [DW-1:0]  instr_q, instr_d;
    logic           imem_en_q, imem_en_d;
    logic           instr_valid_q, instr_valid_d;
    logic           pc_adv_q, pc_adv_d;
    logic           jflag_q, jflag_d;
    logic [AW-1:0]  jaddr_q, jaddr_d;
    logic           halted_q, halted_d;

    logic [OPC_W-1:0] opcode_s;
    logic [AW-1:0]    jump_tgt_s;
    logic [AW-1:0]    branch_tgt_s;

    assign opcode_s     = instr_q[OPC_HI:OPC_LO];
    assign jump_tgt_s   = AW'(instr_q[TGT_HI:TGT_LO]);
    assign branch_tgt_s = Caddr + {{(AW-OFS_W){instr_q[OFS_HI]}}, instr_q[OFS_HI:OFS_LO]};

`ifdef FETCH_CALL_STACK_EN
    logic          stack_push_s, stack_pop_s, stack_empty_s;
    logic [AW-1:0] stack_top_s;
    logic [AW-1:0] ret_addr_s;

    assign ret_addr_s = Caddr + AW'(1'b1);

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .AW    (AW)
    ) u_return_stack (
        .clk       (clk),
        .Clear_n   (Clear_n),
        .push      (stack_push_s),
        .pop       (stack_pop_s),
        .push_addr (ret_addr_s),
        .top_addr  (stack_top_s),
        .empty     (stack_empty_s)
    );
`endif

    // The PC only moves on the SETTLE->FETCH edge, so the ROM address is taken live from Caddr in FETCH.
    assign imem_en     = imem_en_q;
    assign imem_addr   = imem_en_q ? Caddr : {AW{1'b0}};
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc_adv      = pc_adv_q;
    assign Jflag       = jflag_q;
    assign Jaddr       = jaddr_q;
    assign halted      = halted_q;

    // Next-state and next-output logic; PC requests are single-cycle pulses into SETTLE.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc_adv_d = 1'b0;
        jflag_d  = 1'b0;
        jaddr_d  = {AW{1'b0}};
`ifdef FETCH_CALL_STACK_EN
        stack_push_s = 1'b0;
        stack_pop_s  = 1'b0;
`endif
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                instr_d = imem_rdata;
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                case (opcode_s)
                    OP_J: begin
                        jflag_d = 1'b1;
                        jaddr_d = jump_tgt_s;
                        state_d = S_SETTLE;
                    end
                    OP_BEQZ: state_d = S_CWAIT;
                    OP_HALT: state_d = S_HALT;
`ifdef FETCH_CALL_STACK_EN
                    OP_JAL: begin
                        stack_push_s = 1'b1;
                        jflag_d      = 1'b1;
                        jaddr_d      = jump_tgt_s;
                        state_d      = S_SETTLE;
                    end
                    OP_RET: begin
                        if (!stack_empty_s) begin
                            stack_pop_s = 1'b1;
                            jflag_d     = 1'b1;
                            jaddr_d     = stack_top_s;
                            state_d     = S_SETTLE;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end
`endif
                    default: state_d = S_ISSUE;
                endcase
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    pc_adv_d = 1'b1;
                    state_d  = S_SETTLE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_CWAIT: begin
                if (cond_valid) begin
                    if (cond_zero) begin
                        jflag_d = 1'b1;
                        jaddr_d = branch_tgt_s;
                    end else begin
                        pc_adv_d = 1'b1;
                    end
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_CWAIT;
                end
            end
            S_SETTLE: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
        imem_en_d     = (state_d == S_FETCH);
        instr_valid_d = (state_d == S_ISSUE);
        halted_d      = (state_d == S_HALT);
    end

    // State and output registers; reset discards any pending instruction.
    always_ff @(posedge clk) begin
        if (!Clear_n) begin
            state_q       <= S_IDLE;
            instr_q       <= {DW{1'b0}};
            imem_en_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            pc_adv_q      <= 1'b0;
            jflag_q       <= 1'b0;
            jaddr_q       <= {AW{1'b0}};
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            imem_en_q     <= imem_en_d;
            instr_valid_q <= instr_valid_d;
            pc_adv_q      <= pc_adv_d;
            jflag_q       <= jflag_d;
            jaddr_q       <= jaddr_d;
            halted_q      <= halted_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a PC model, a synchronous ROM
// model and an event scoreboard (FETCH/JUMP/ADV/ISSUE events).
module tb_fetch_sequencer;

    localparam logic [1:0]  K_ISSUE = 2'd0;
    localparam logic [1:0]  K_ADV   = 2'd1;
    localparam logic [1:0]  K_JUMP  = 2'd2;
    localparam logic [1:0]  K_FETCH = 2'd3;
    localparam logic [17:0] NO_EV   = 18'h3FFFF;

    logic        clk;
    logic        clear_n;
    logic [9:0]  pc;
    logic [9:0]  pc_init;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [15:0] rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        cond_valid;
    logic        cond_zero;
    logic        pc_adv;
    logic        jflag;
    logic [9:0]  jaddr;
    logic        halted;

    logic [15:0] rom [0:1023];
    logic [17:0] obs_q [$];
    logic [17:0] exp_q [$];
    logic        iv_prev;
    logic [15:0] iv_instr;
    int          hold_err;
    int          both_err;
    int          chk_cnt;
    int          pass_cnt;

    fetch_sequencer dut (
        .clk         (clk),
        .Clear_n     (clear_n),
        .Caddr       (pc),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .cond_valid  (cond_valid),
        .cond_zero   (cond_zero),
        .pc_adv      (pc_adv),
        .Jflag       (jflag),
        .Jaddr       (jaddr),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter owned by the environment: load wins, then increment, wrapping at 10 bits.
    always @(posedge clk) begin
        if (!clear_n) pc <= pc_init;
        else if (jflag) pc <= jaddr;
        else if (pc_adv) pc <= pc + 10'd1;
    end

    // Synchronous ROM: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (imem_en) rdata <= rom[imem_addr];
        else rdata <= 16'hDEAD;
    end

    // Output monitor: turns DUT activity into scoreboard events.
    always @(negedge clk) begin
        if (imem_en) obs_q.push_back({K_FETCH, 6'd0, imem_addr});
        if (jflag) obs_q.push_back({K_JUMP, 6'd0, jaddr});
        if (pc_adv) obs_q.push_back({K_ADV, 16'd0});
        if (instr_valid && !iv_prev) obs_q.push_back({K_ISSUE, instr});
        if (instr_valid && iv_prev && (instr !== iv_instr)) hold_err <= hold_err + 1;
        if (jflag && pc_adv) both_err <= both_err + 1;
        iv_prev  <= instr_valid;
        iv_instr <= instr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [9:0] start_pc);
        clear_n = 1'b0;
        pc_init = start_pc;
        repeat (3) tick();
        obs_q.delete();
        exp_q.delete();
        clear_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [9:0] z10;
        z10 = 10'h000;
        rom[5] = 16'h1234;
        instr_ready = 1'b1;
        clear_n = 1'b0;
        pc_init = 10'd5;
        repeat (3) tick();
        chk_cnt++;
        if ({imem_en, instr_valid, pc_adv, jflag, halted} !== 5'b00000 || instr !== 16'h0000
            || jaddr !== z10 || imem_addr !== z10)
            $display("FAIL reset_outputs: got en=%b v=%b adv=%b j=%b h=%b instr=%h ja=%h ia=%h required all 0",
                     imem_en, instr_valid, pc_adv, jflag, halted, instr, jaddr, imem_addr);
        else pass_cnt++;
        clear_n = 1'b1;
        tick();
        chk_cnt++;
        if (imem_en !== 1'b1 || imem_addr !== 10'd5)
            $display("FAIL first_fetch: got en=%b addr=%0d required en=1 addr=5", imem_en, imem_addr);
        else pass_cnt++;
        tick();
        tick();
        chk_cnt++;
        if (instr_valid !== 1'b0)
            $display("FAIL early_valid: got %b required 0", instr_valid);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (instr_valid !== 1'b1 || instr !== 16'h1234)
            $display("FAIL first_issue: got v=%b instr=%h required v=1 instr=1234", instr_valid, instr);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (pc_adv !== 1'b1 || jflag !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL first_adv: got adv=%b j=%b v=%b required adv=1 j=0 v=0", pc_adv, jflag, instr_valid);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (pc_adv !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 10'd6)
            $display("FAIL second_fetch: got adv=%b en=%b addr=%0d required adv=0 en=1 addr=6",
                     pc_adv, imem_en, imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int bad;
        int hb;
        bad = 0;
        rom[20] = 16'h1111;
        instr_ready = 1'b0;
        start(10'd20);
        for (int c = 0; c < 10 && !instr_valid; c++) tick();
        chk_cnt++;
        if (instr_valid !== 1'b1) $display("FAIL bp_valid: got %b required 1", instr_valid);
        else pass_cnt++;
        hb = hold_err;
        cond_valid = 1'b1;
        cond_zero  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (instr_valid !== 1'b1 || instr !== 16'h1111 || pc_adv !== 1'b0 || jflag !== 1'b0) bad++;
        end
        chk_cnt++;
        if (bad != 0 || hold_err != hb)
            $display("FAIL bp_hold: got %0d bad cycles %0d changes required 0 and 0", bad, hold_err - hb);
        else pass_cnt++;
        instr_ready = 1'b1;
        cond_valid  = 1'b0;
        tick();
        chk_cnt++;
        if (pc_adv !== 1'b1 || instr_valid !== 1'b0)
            $display("FAIL bp_accept: got adv=%b v=%b required adv=1 v=0", pc_adv, instr_valid);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (pc_adv !== 1'b0) $display("FAIL bp_single_adv: got %b required 0", pc_adv);
        else pass_cnt++;
    endtask

    task automatic test_jump();
        logic [17:0] e, o;
        int idx;
        rom[7]    = 16'hA0F0;
        rom[10'hF0] = 16'h0042;
        rom[10'hF1] = 16'hA0F1;
        instr_ready = 1'b1;
        start(10'd7);
        exp_q.push_back({K_FETCH, 16'd7});
        exp_q.push_back({K_JUMP,  16'h00F0});
        exp_q.push_back({K_FETCH, 16'h00F0});
        exp_q.push_back({K_ISSUE, 16'h0042});
        exp_q.push_back({K_ADV,   16'h0000});
        exp_q.push_back({K_FETCH, 16'h00F1});
        exp_q.push_back({K_JUMP,  16'h00F1});
        exp_q.push_back({K_FETCH, 16'h00F1});
        exp_q.push_back({K_JUMP,  16'h00F1});
        for (int c = 0; c < 80 && obs_q.size() < exp_q.size(); c++) tick();
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : NO_EV;
            chk_cnt++;
            if (o !== e) $display("FAIL jump_seq[%0d]: got %h required %h", idx, o, e);
            else pass_cnt++;
            idx++;
        end
    endtask

    task automatic test_branch_taken();
        logic [17:0] e, o;
        int idx;
        rom[2]    = 16'hB0FC;
        rom[1022] = 16'h1357;
        rom[1023] = 16'h5555;
        instr_ready = 1'b1;
        cond_valid  = 1'b0;
        cond_zero   = 1'b0;
        start(10'd2);
        repeat (6) tick();
        chk_cnt++;
        if (obs_q.size() != 1) $display("FAIL beqz_wait: got %0d events required 1", obs_q.size());
        else pass_cnt++;
        cond_valid = 1'b1;
        cond_zero  = 1'b1;
        tick();
        cond_valid = 1'b0;
        cond_zero  = 1'b0;
        exp_q.push_back({K_FETCH, 16'd2});
        exp_q.push_back({K_JUMP,  16'd1022});
        exp_q.push_back({K_FETCH, 16'd1022});
        exp_q.push_back({K_ISSUE, 16'h1357});
        exp_q.push_back({K_ADV,   16'h0000});
        exp_q.push_back({K_FETCH, 16'd1023});
        exp_q.push_back({K_ISSUE, 16'h5555});
        exp_q.push_back({K_ADV,   16'h0000});
        exp_q.push_back({K_FETCH, 16'd0});
        for (int c = 0; c < 80 && obs_q.size() < exp_q.size(); c++) tick();
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : NO_EV;
            chk_cnt++;
            if (o !== e) $display("FAIL beqz_taken[%0d]: got %h required %h", idx, o, e);
            else pass_cnt++;
            idx++;
        end
    endtask

    task automatic test_branch_not_taken();
        logic [17:0] e, o;
        int idx;
        rom[3] = 16'h0000;
        instr_ready = 1'b1;
        cond_valid  = 1'b1;
        cond_zero   = 1'b0;
        start(10'd2);
        exp_q.push_back({K_FETCH, 16'd2});
        exp_q.push_back({K_ADV,   16'h0000});
        exp_q.push_back({K_FETCH, 16'd3});
        for (int c = 0; c < 40 && obs_q.size() < exp_q.size(); c++) tick();
        cond_valid = 1'b0;
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : NO_EV;
            chk_cnt++;
            if (o !== e) $display("FAIL beqz_not_taken[%0d]: got %h required %h", idx, o, e);
            else pass_cnt++;
            idx++;
        end
    endtask

    task automatic test_halt();
        logic [17:0] e, o;
        int idx;
        int bad;
        bad = 0;
        rom[8] = 16'h0777;
        rom[9] = 16'hF000;
        instr_ready = 1'b1;
        start(10'd8);
        exp_q.push_back({K_FETCH, 16'd8});
        exp_q.push_back({K_ISSUE, 16'h0777});
        exp_q.push_back({K_ADV,   16'h0000});
        exp_q.push_back({K_FETCH, 16'd9});
        for (int c = 0; c < 40 && !halted; c++) tick();
        chk_cnt++;
        if (halted !== 1'b1) $display("FAIL halt_entry: got %b required 1", halted);
        else pass_cnt++;
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : NO_EV;
            chk_cnt++;
            if (o !== e) $display("FAIL halt_seq[%0d]: got %h required %h", idx, o, e);
            else pass_cnt++;
            idx++;
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (imem_en !== 1'b0 || pc_adv !== 1'b0 || jflag !== 1'b0 || halted !== 1'b1) bad++;
        end
        chk_cnt++;
        if (bad != 0 || obs_q.size() != 0)
            $display("FAIL halt_quiet: got %0d bad cycles %0d events required 0 and 0", bad, obs_q.size());
        else pass_cnt++;
        clear_n = 1'b0;
        tick();
        chk_cnt++;
        if (halted !== 1'b0 || imem_en !== 1'b0)
            $display("FAIL halt_clear: got h=%b en=%b required h=0 en=0", halted, imem_en);
        else pass_cnt++;
        clear_n = 1'b1;
        tick();
        chk_cnt++;
        if (imem_en !== 1'b1 || imem_addr !== 10'd8)
            $display("FAIL halt_restart: got en=%b addr=%0d required en=1 addr=8", imem_en, imem_addr);
        else pass_cnt++;
    endtask

`ifdef FETCH_CALL_STACK_EN
    task automatic test_call_stack();
        logic [17:0] e, o;
        int idx;
        rom[100] = 16'hC0C8;
        rom[200] = 16'hC12C;
        rom[300] = 16'hC190;
        rom[400] = 16'hC1F4;
        rom[500] = 16'hC258;
        rom[600] = 16'hD000;
        rom[501] = 16'hD000;
        rom[401] = 16'hD000;
        rom[301] = 16'hD000;
        rom[201] = 16'hD000;
        rom[202] = 16'hF000;
        instr_ready = 1'b1;
        start(10'd100);
        exp_q.push_back({K_FETCH, 16'd100});
        exp_q.push_back({K_JUMP,  16'd200});
        exp_q.push_back({K_FETCH, 16'd200});
        exp_q.push_back({K_JUMP,  16'd300});
        exp_q.push_back({K_FETCH, 16'd300});
        exp_q.push_back({K_JUMP,  16'd400});
        exp_q.push_back({K_FETCH, 16'd400});
        exp_q.push_back({K_JUMP,  16'd500});
        exp_q.push_back({K_FETCH, 16'd500});
        exp_q.push_back({K_JUMP,  16'd600});
        exp_q.push_back({K_FETCH, 16'd600});
        exp_q.push_back({K_JUMP,  16'd501});
        exp_q.push_back({K_FETCH, 16'd501});
        exp_q.push_back({K_JUMP,  16'd401});
        exp_q.push_back({K_FETCH, 16'd401});
        exp_q.push_back({K_JUMP,  16'd301});
        exp_q.push_back({K_FETCH, 16'd301});
        exp_q.push_back({K_JUMP,  16'd201});
        exp_q.push_back({K_FETCH, 16'd201});
        exp_q.push_back({K_ISSUE, 16'hD000});
        exp_q.push_back({K_ADV,   16'h0000});
        exp_q.push_back({K_FETCH, 16'd202});
        for (int c = 0; c < 200 && obs_q.size() < exp_q.size(); c++) tick();
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : NO_EV;
            chk_cnt++;
            if (o !== e) $display("FAIL call_stack[%0d]: got %h required %h", idx, o, e);
            else pass_cnt++;
            idx++;
        end
    endtask
`endif

    task automatic test_invariants();
        chk_cnt++;
        if (both_err != 0) $display("FAIL jflag_and_adv: got %0d overlapping cycles required 0", both_err);
        else pass_cnt++;
    endtask

    initial begin
        chk_cnt     = 0;
        pass_cnt    = 0;
        hold_err    = 0;
        both_err    = 0;
        iv_prev     = 1'b0;
        iv_instr    = 16'h0000;
        clear_n     = 1'b0;
        pc_init     = 10'd0;
        instr_ready = 1'b0;
        cond_valid  = 1'b0;
        cond_zero   = 1'b0;
        for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
        test_reset();
        test_backpressure();
        test_jump();
        test_branch_taken();
        test_branch_not_taken();
        test_halt();
`ifdef FETCH_CALL_STACK_EN
        test_call_stack();
`endif
        test_invariants();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
